// File: rtl/bg_color_pkg.sv
// Shared types and code constants for the background color scheduler.
package bg_color_pkg;

    typedef logic [2:0] color_code_t;

    typedef enum logic [1:0] {
        IDLE,
        CYCLE,
        FLASH_HIT,
        FLASH_LEVEL
    } bg_state_t;

    localparam color_code_t CODE_IDLE  = 3'b000;
    localparam color_code_t CODE_LEVEL = 3'b110;
    localparam color_code_t CODE_HIT   = 3'b111;

endpackage

// File: rtl/bg_color_scheduler_sof_divider.sv
// Frame-pulse divider: counts qualified startOfFrame pulses up to LIMIT.
// done is a combinational one-clk pulse on the pulse that reaches LIMIT;
// the counter wraps to zero on that same edge. clear has priority.
module sof_divider #(
    parameter int unsigned LIMIT = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic pulse,
    output logic done
);

    localparam int unsigned W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    assign done = pulse && (count == LAST);

    // Pulse counter with synchronous clear; never holds a value above LIMIT-1.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (pulse) begin
            count <= done ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/bg_color_scheduler.sv
// Background color-code sequencer/arbiter: ambient palette stepping plus
// one-shot flash grants (level > hit). Optional macro BG_PINGPONG_EN makes the
// ambient index bounce 0 -> CYCLE_LAST -> 0 instead of wrapping.
module bg_color_scheduler
    import bg_color_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP = 30,
    parameter int unsigned FLASH_FRAMES    = 15,
    parameter int unsigned CYCLE_LAST      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        hitReq,
    input  logic        levelReq,
    output logic        hitAck,
    output logic        levelAck,
    output logic [2:0]  generatedColorCode,
    output logic        flashActive
);

    localparam color_code_t CL = color_code_t'(CYCLE_LAST);

    bg_state_t   state, state_nx;
    color_code_t idx, idx_nx, code_nx;
    logic        hit_blk, lvl_blk;
    logic        grant_hit, grant_lvl;
    logic        in_flash, nx_flash;
    logic        amb_pulse, amb_done, amb_clr;
    logic        fl_pulse, fl_done, fl_clr;
`ifdef BG_PINGPONG_EN
    logic        dir_up, dir_nx;
`endif

    assign in_flash = (state == FLASH_HIT) || (state == FLASH_LEVEL);
    assign nx_flash = (state_nx == FLASH_HIT) || (state_nx == FLASH_LEVEL);

    // Arbitration: a request is eligible only after dropping since its last grant.
    always_comb begin
        grant_hit = 1'b0;
        grant_lvl = 1'b0;
        case (state)
            IDLE, CYCLE: begin
                if (levelReq && !lvl_blk)    grant_lvl = 1'b1;
                else if (hitReq && !hit_blk) grant_hit = 1'b1;
            end
            FLASH_HIT: begin
                if (levelReq && !lvl_blk)    grant_lvl = 1'b1;
            end
            default: ;
        endcase
    end

    // A grant swallows a coincident frame pulse for both dividers.
    assign amb_pulse = startOfFrame && (state == CYCLE) && !grant_lvl && !grant_hit;
    assign fl_pulse  = startOfFrame && in_flash && !grant_lvl;
    assign amb_clr   = (state_nx == IDLE) || (in_flash && state_nx == CYCLE);
    assign fl_clr    = grant_lvl || grant_hit || !nx_flash;

    sof_divider #(.LIMIT(FRAMES_PER_STEP)) u_amb_div (
        .clk   (clk),
        .reset (reset),
        .clear (amb_clr),
        .pulse (amb_pulse),
        .done  (amb_done)
    );

    sof_divider #(.LIMIT(FLASH_FRAMES)) u_flash_div (
        .clk   (clk),
        .reset (reset),
        .clear (fl_clr),
        .pulse (fl_pulse),
        .done  (fl_done)
    );

    // Next-state, ambient index and next registered output code.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
`ifdef BG_PINGPONG_EN
        dir_nx   = dir_up;
`endif
        if (grant_lvl) begin
            state_nx = FLASH_LEVEL;
        end else if (grant_hit) begin
            state_nx = FLASH_HIT;
        end else begin
            case (state)
                IDLE, CYCLE: begin
                    state_nx = enable ? CYCLE : IDLE;
                    if (enable && amb_done) begin
`ifdef BG_PINGPONG_EN
                        if (dir_up) begin
                            idx_nx = idx + 3'd1;
                            if (idx_nx == CL) dir_nx = 1'b0;
                        end else begin
                            idx_nx = idx - 3'd1;
                            if (idx_nx == '0) dir_nx = 1'b1;
                        end
`else
                        idx_nx = (idx == CL) ? '0 : idx + 3'd1;
`endif
                    end
                end
                FLASH_HIT, FLASH_LEVEL: begin
                    if (fl_done) state_nx = enable ? CYCLE : IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state_nx == IDLE) begin
            idx_nx = '0;
`ifdef BG_PINGPONG_EN
            dir_nx = 1'b1;
`endif
        end
        case (state_nx)
            FLASH_HIT:   code_nx = CODE_HIT;
            FLASH_LEVEL: code_nx = CODE_LEVEL;
            CYCLE:       code_nx = idx_nx;
            default:     code_nx = CODE_IDLE;
        endcase
    end

    // State, index, request blocking flags and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            idx                <= '0;
            hit_blk            <= 1'b0;
            lvl_blk            <= 1'b0;
            hitAck             <= 1'b0;
            levelAck           <= 1'b0;
            flashActive        <= 1'b0;
            generatedColorCode <= CODE_IDLE;
`ifdef BG_PINGPONG_EN
            dir_up             <= 1'b1;
`endif
        end else begin
            state              <= state_nx;
            idx                <= idx_nx;
            hit_blk            <= grant_hit || (hit_blk && hitReq);
            lvl_blk            <= grant_lvl || (lvl_blk && levelReq);
            hitAck             <= grant_hit;
            levelAck           <= grant_lvl;
            flashActive        <= nx_flash;
            generatedColorCode <= code_nx;
`ifdef BG_PINGPONG_EN
            dir_up             <= dir_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bg_color_scheduler.sv
// Directed self-checking bench for bg_color_scheduler
// (FRAMES_PER_STEP=2, FLASH_FRAMES=15, CYCLE_LAST=5).
module tb_bg_color_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       enable = 1'b0;
    logic       hitReq = 1'b0;
    logic       levelReq = 1'b0;
    logic       hitAck, levelAck, flashActive;
    logic [2:0] generatedColorCode;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned hit_acks = 0;
    int unsigned base;
    int          amb_seq [14];

    always #5 clk = ~clk;

    bg_color_scheduler #(
        .FRAMES_PER_STEP (2),
        .FLASH_FRAMES    (15),
        .CYCLE_LAST      (5)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .enable             (enable),
        .hitReq             (hitReq),
        .levelReq           (levelReq),
        .hitAck             (hitAck),
        .levelAck           (levelAck),
        .generatedColorCode (generatedColorCode),
        .flashActive        (flashActive)
    );

    always @(negedge clk) begin
        if (hitAck === 1'b1) hit_acks++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
`ifdef BG_PINGPONG_EN
        amb_seq = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 4, 4, 3};
`else
        amb_seq = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 0, 0, 1};
`endif
        // Reset values
        tick(); tick(); tick();
        check("rst_code", generatedColorCode, 0);
        check("rst_hitack", hitAck, 0);
        check("rst_lvlack", levelAck, 0);
        check("rst_flash", flashActive, 0);

        // Ambient stepping every second frame
        reset = 1'b0;
        enable = 1'b1;
        tick();
        check("cycle_start", generatedColorCode, 0);
        for (int k = 0; k < 14; k++) begin
            frame();
            check($sformatf("amb_%0d", k + 1), generatedColorCode, amb_seq[k]);
            check($sformatf("amb_noack_%0d", k + 1), {hitAck, levelAck}, 0);
        end

        // Hit flash from index 3, resume at 3, then step to 4
        reset = 1'b1; tick(); reset = 1'b0; tick();
        frames(6);
        check("idx3", generatedColorCode, 3);
        hitReq = 1'b1;
        tick();
        check("hit_ack", hitAck, 1);
        check("hit_code", generatedColorCode, 7);
        check("hit_flash", flashActive, 1);
        hitReq = 1'b0;
        tick();
        check("hit_ack_1clk", hitAck, 0);
        frames(14);
        check("hit_hold14", generatedColorCode, 7);
        frame();
        check("hit_resume", generatedColorCode, 3);
        check("hit_resume_fa", flashActive, 0);
        frame();
        check("resume_cnt_clr", generatedColorCode, 3);
        frame();
        check("resume_step", generatedColorCode, 4);

        // Simultaneous requests: level first, hit waits for the flash to end
        hitReq = 1'b1;
        levelReq = 1'b1;
        tick();
        check("both_lvlack", levelAck, 1);
        check("both_hitack", hitAck, 0);
        check("both_code", generatedColorCode, 6);
        levelReq = 1'b0;
        tick();
        check("both_lvlack_1clk", levelAck, 0);
        frames(14);
        check("pend_hit_noack", hitAck, 0);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("lvl_end_code", generatedColorCode, 4);
        check("lvl_end_hitack", hitAck, 0);
        tick();
        check("pend_hit_ack", hitAck, 1);
        check("pend_hit_code", generatedColorCode, 7);
        hitReq = 1'b0;
        frames(15);
        check("pend_hit_end", generatedColorCode, 4);

        // Level preempts hit at flash count 10, coincident frame not counted
        hitReq = 1'b1;
        tick();
        hitReq = 1'b0;
        frames(10);
        levelReq = 1'b1;
        startOfFrame = 1'b1;
        tick();
        levelReq = 1'b0;
        startOfFrame = 1'b0;
        check("preempt_ack", levelAck, 1);
        check("preempt_code", generatedColorCode, 6);
        frames(14);
        check("preempt_hold14", generatedColorCode, 6);
        frame();
        check("preempt_end", generatedColorCode, 4);
        check("preempt_end_fa", flashActive, 0);

        // Request held past its ack is not re-granted until it drops
        base = hit_acks;
        hitReq = 1'b1;
        tick();
        check("held_ack", hitAck, 1);
        frames(15);
        tick(); tick(); tick();
        check("held_no_regrant", generatedColorCode, 4);
        check("held_ack_count", hit_acks, base + 1);
        hitReq = 1'b0;
        tick();
        hitReq = 1'b1;
        tick();
        check("rearm_ack", hitAck, 1);
        check("rearm_code", generatedColorCode, 7);
        hitReq = 1'b0;
        frames(15);
        check("rearm_end", generatedColorCode, 4);

        // Enable dropped mid-flash: flash completes, then idle code
        levelReq = 1'b1;
        tick();
        levelReq = 1'b0;
        frames(5);
        enable = 1'b0;
        frames(9);
        check("en_low_hold", generatedColorCode, 6);
        frame();
        check("en_low_idle", generatedColorCode, 0);
        check("en_low_fa", flashActive, 0);
        enable = 1'b1;
        tick();
        frames(2);
        check("en_low_idx0", generatedColorCode, 1);

        // Reset mid-flash, then request still high is granted right after release
        hitReq = 1'b1;
        tick();
        frames(3);
        reset = 1'b1;
        tick();
        check("rst_mid_code", generatedColorCode, 0);
        check("rst_mid_fa", flashActive, 0);
        reset = 1'b0;
        tick();
        check("post_rst_ack", hitAck, 1);
        check("post_rst_code", generatedColorCode, 7);
        hitReq = 1'b0;
        frames(15);
        check("post_rst_end", generatedColorCode, 0);
        frames(2);
        check("post_rst_step", generatedColorCode, 1);

        // enable low in CYCLE parks at idle and clears the index
        enable = 1'b0;
        tick();
        check("park_code", generatedColorCode, 0);
        enable = 1'b1;
        tick();
        frames(2);
        check("park_restart", generatedColorCode, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
